// File: rtl/lsu_async.sv
// lsu_async: single-outstanding load/store unit bridging the M stage to a
// req/ack memory bus. Sub-word accesses are placed into byte lanes on the
// way out, and loads are realigned and sign/zero-extended on the way back.
//
// Handshake: bus_req rises with the request bundle and stays high, with
// every bus output frozen, until the cycle in which bus_ack is sampled high;
// bus_ack has no meaning while bus_req is low. A stuck access is abandoned
// after TIMEOUT_CYCLES wait cycles and flags err_timeout until reset.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN): when defined, an access
// whose offset is not a multiple of its size is not sent to the bus; it
// completes in one stall cycle with a misalign pulse and zero load data.
// When undefined, the offending low address bits are simply dropped.
//
// dbg_state exposes the FSM state (0 IDLE, 1 WAIT, 2 DONE) for observation.
module lsu_async #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [2:0]        funct3_m,
    input  logic [XLEN-1:0]   addr_m,
    input  logic [XLEN-1:0]   wdata_m,
    output logic              stall_m,
    output logic [XLEN-1:0]   load_data_w,
    output logic              load_valid_w,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_be,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_ack,
    output logic              err_timeout,
    output logic              misalign,
    output logic [1:0]        dbg_state
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic              r_is_load;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFFW-1:0]   r_off;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [XLEN-1:0]   r_bus_addr;
    logic [XLEN-1:0]   r_bus_wdata;
    logic [NB-1:0]     r_bus_be;
    logic [XLEN-1:0]   r_load_data;
    logic              r_load_valid;
    logic              r_err_timeout;

    logic              w_req;
    logic [1:0]        w_size;     // log2 of access size in bytes
    logic              w_uns;
    logic [OFFW-1:0]   w_lowmask;  // offset bits that must be zero for this size
    logic [OFFW-1:0]   w_off;
    logic [NB-1:0]     w_be_base;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_baddr;
    logic [XLEN-1:0]   w_rd_sh;
    logic              w_fill;
    int                w_nbits;
    logic [XLEN-1:0]   w_ext;

    assign w_req = mem_read_m | mem_write_m;

    // Decode funct3 into size and signedness; anything unsupported acts as a signed word.
    always_comb begin
        w_size = 2'd2;
        w_uns  = 1'b0;
        case (funct3_m)
            3'b000: w_size = 2'd0;
            3'b001: w_size = 2'd1;
            3'b011: if (XLEN == 64) w_size = 2'd3;
            3'b100: begin w_size = 2'd0; w_uns = 1'b1; end
            3'b101: begin w_size = 2'd1; w_uns = 1'b1; end
            3'b110: if (XLEN == 64) w_uns = 1'b1;
            default: ;
        endcase
    end

    // Lane placement: byte enables, shifted store data and word-aligned address.
    always_comb begin
        case (w_size)
            2'd0:    begin w_lowmask = OFFW'(0); w_be_base = NB'(8'h01); end
            2'd1:    begin w_lowmask = OFFW'(1); w_be_base = NB'(8'h03); end
            2'd2:    begin w_lowmask = OFFW'(3); w_be_base = NB'(8'h0F); end
            default: begin w_lowmask = OFFW'(7); w_be_base = NB'(8'hFF); end
        endcase
        w_off   = addr_m[OFFW-1:0] & ~w_lowmask;
        w_be    = w_be_base << w_off;
        w_wdata = wdata_m << {w_off, 3'b000};
        w_baddr = {addr_m[XLEN-1:OFFW], {OFFW{1'b0}}};
    end

    // Realign returned data using the offset captured at issue, then extend.
    always_comb begin
        w_rd_sh = bus_rdata >> {r_off, 3'b000};
        case (r_size)
            2'd0:    begin w_nbits = 8;    w_fill = ~r_uns & w_rd_sh[7];  end
            2'd1:    begin w_nbits = 16;   w_fill = ~r_uns & w_rd_sh[15]; end
            2'd2:    begin w_nbits = 32;   w_fill = ~r_uns & w_rd_sh[31]; end
            default: begin w_nbits = XLEN; w_fill = 1'b0;                 end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            w_ext[i] = (i < w_nbits) ? w_rd_sh[i] : w_fill;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misal_hit;
    logic r_misalign;
    assign w_misal_hit = |(addr_m[OFFW-1:0] & w_lowmask);
    assign misalign    = r_misalign;
`else
    assign misalign    = 1'b0;
`endif

    // Access FSM: issue from IDLE, hold the bus in WAIT, one-cycle DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_is_load     <= 1'b0;
            r_size        <= 2'd0;
            r_uns         <= 1'b0;
            r_off         <= '0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_be      <= '0;
            r_load_data   <= '0;
            r_load_valid  <= 1'b0;
            r_err_timeout <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_load <= ~mem_write_m;
                        r_size    <= w_size;
                        r_uns     <= w_uns;
                        r_off     <= w_off;
                        r_cnt     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misal_hit) begin
                            r_state      <= S_DONE;
                            r_load_data  <= '0;
                            r_load_valid <= ~mem_write_m;
                            r_misalign   <= 1'b1;
                        end else begin
                            r_state     <= S_WAIT;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write_m;
                            r_bus_addr  <= w_baddr;
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end
`else
                        r_state     <= S_WAIT;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_write_m;
                        r_bus_addr  <= w_baddr;
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (r_is_load) begin
                            r_load_data  <= w_ext;
                            r_load_valid <= 1'b1;
                        end
                    end else if (r_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
                        r_bus_req     <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_load_data   <= '0;
                        r_load_valid  <= r_is_load;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_m      = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_be       = r_bus_be;
    assign load_data_w  = r_load_data;
    assign load_valid_w = r_load_valid;
    assign err_timeout  = r_err_timeout;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_lsu_async.sv
// tb_lsu_async: directed and randomized accesses against lsu_async with a
// bus responder, a load-data scoreboard and per-cycle bus stability checks.
module tb_lsu_async;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              mem_read_m, mem_write_m;
    logic [2:0]        funct3_m;
    logic [XLEN-1:0]   addr_m, wdata_m;
    logic              stall_m;
    logic [XLEN-1:0]   load_data_w;
    logic              load_valid_w;
    logic              bus_req, bus_we;
    logic [XLEN-1:0]   bus_addr, bus_wdata;
    logic [XLEN/8-1:0] bus_be;
    logic [XLEN-1:0]   bus_rdata;
    logic              bus_ack;
    logic              err_timeout, misalign;
    logic [1:0]        dbg_state;

    lsu_async #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .stall_m(stall_m), .load_data_w(load_data_w), .load_valid_w(load_valid_w),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .err_timeout(err_timeout), .misalign(misalign), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    logic            e_we;
    logic [31:0]     e_addr, e_wdata;
    logic [3:0]      e_be;
    logic            resp_en;
    int              resp_dly, resp_cnt;
    logic [31:0]     resp_data;
    int              req_cycles = 0;
    int              n_valid    = 0;
    int              n_misal    = 0;

    // Reference models (naturally aligned view of the access)
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: model_be = 4'b0001 << a[1:0];
            3'b001, 3'b101: model_be = a[1] ? 4'b1100 : 4'b0011;
            default:        model_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] wd);
        case (f3)
            3'b000, 3'b100: model_wdata = wd << {a[1:0], 3'b000};
            3'b001, 3'b101: model_wdata = a[1] ? {wd[15:0], 16'h0} : wd;
            default:        model_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {a[1:0], 3'b000});
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  model_load = {{24{b[7]}}, b};
            3'b100:  model_load = {24'h0, b};
            3'b001:  model_load = {{16{h[15]}}, h};
            3'b101:  model_load = {16'h0, h};
            default: model_load = rd;
        endcase
    endfunction

    // One cycle: advance to the falling edge, score load results, check the
    // bus bundle while a request is up and drive the responder.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (load_valid_w) begin
            n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_valid: unexpected pulse with data %h, nothing expected", load_data_w);
            end else begin
                e = exp_q.pop_front();
                if (load_data_w !== e) begin
                    n_fail++;
                    $display("FAIL load_data: got %h expected %h", load_data_w, e);
                end
            end
        end
        if (misalign) n_misal++;
        if (bus_req) begin
            req_cycles++;
            n_checks++;
            if ({bus_we, bus_be, bus_addr, bus_wdata} !== {e_we, e_be, e_addr, e_wdata}) begin
                n_fail++;
                $display("FAIL bus_bundle: got we=%b be=%h addr=%h wdata=%h expected we=%b be=%h addr=%h wdata=%h",
                         bus_we, bus_be, bus_addr, bus_wdata, e_we, e_be, e_addr, e_wdata);
            end
            if (resp_en && resp_cnt == resp_dly) begin
                bus_ack   = 1'b1;
                bus_rdata = resp_data;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
            end
            resp_cnt++;
        end else begin
            bus_ack  = 1'b0;
            resp_cnt = 0;
        end
    endtask

    // Present one request and hold it until the pipeline is released.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                          input int exp_stall, input int exp_req, input logic [31:0] exp_data,
                          input string name);
        int   stalls;
        int   v0;
        logic done;
        e_we      = wr;
        e_addr    = {addr[31:2], 2'b00};
        e_be      = model_be(f3, addr);
        e_wdata   = model_wdata(f3, addr, wdata);
        resp_en   = 1'b1;
        resp_dly  = dly;
        resp_data = rdata;
        resp_cnt  = 0;
        req_cycles = 0;
        v0        = n_valid;
        if (!wr) exp_q.push_back(exp_data);
        mem_read_m  = ~wr;
        mem_write_m = wr;
        funct3_m    = f3;
        addr_m      = addr;
        wdata_m     = wdata;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (stall_m) begin
                stalls++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_complete: stall never released within 100 cycles", name);
        end
        // Request stays presented through DONE; it must not be reissued.
        tick();
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || dbg_state !== 2'd0 || stall_m !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_no_reissue: bus_req=%b state=%0d stall=%b expected 0/0/0", name, bus_req, dbg_state, stall_m);
        end
        n_checks++;
        if (stalls != exp_stall) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d cycles expected %0d", name, stalls, exp_stall);
        end
        n_checks++;
        if (req_cycles != exp_req) begin
            n_fail++;
            $display("FAIL %s_wait: bus_req high %0d cycles expected %0d", name, req_cycles, exp_req);
        end
        n_checks++;
        if ((n_valid - v0) != (wr ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s_valid_pulses: got %0d expected %0d", name, n_valid - v0, wr ? 0 : 1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: %0d results outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
            n_fail++;
            $display("FAIL %s_bus: got req=%b we=%b be=%h addr=%h wdata=%h expected all 0",
                     name, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        n_checks++;
        if ({load_data_w, load_valid_w, err_timeout, misalign, stall_m, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL %s_ctrl: got data=%h valid=%b err=%b mis=%b stall=%b state=%0d expected all 0",
                     name, load_data_w, load_valid_w, err_timeout, misalign, stall_m, dbg_state);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'b000;
        addr_m = '0; wdata_m = '0; bus_ack = 1'b0; bus_rdata = '0;
        resp_en = 1'b0; resp_dly = -1; resp_cnt = 0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        n_rst = 1'b1;
        tick();
        check_reset_values("post_reset");
    endtask

    task automatic test_lw();
        access(1'b0, 3'b010, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 32'hDEAD_BEEF, "lw");
        repeat (3) tick();
        n_checks++;
        if (load_data_w !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lw_hold: got %h expected deadbeef", load_data_w);
        end
    endtask

    task automatic test_lb_lbu();
        access(1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h8000_0000, 1, 3, 2, 32'hFFFF_FF80, "lb");
        access(1'b0, 3'b100, 32'h1000_0003, 32'h0, 32'h8000_0000, 0, 2, 1, 32'h0000_0080, "lbu");
    endtask

    task automatic test_sh();
        access(1'b1, 3'b001, 32'h1000_0002, 32'h0000_1234, 32'h5555_5555, 5, 7, 6, 32'h0, "sh");
        n_checks++;
        if (load_data_w !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL sh_load_data_held: got %h expected 00000080", load_data_w);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        int          dly;
        for (int i = 0; i < 24; i++) begin
            wr  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 4);
`ifdef LSU_MISALIGN_TRAP_EN
            if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
            else if (f3 != 3'b000 && f3 != 3'b100) a[1:0] = 2'b00;
`endif
            access(wr, f3, a, wd, rd, dly, dly + 2, dly + 1, model_load(f3, a, rd), "rand");
        end
    endtask

    task automatic test_misalign();
        int m0;
        m0 = n_misal;
`ifdef LSU_MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 32'h0, "mis_trap");
        n_checks++;
        if (n_misal - m0 != 1) begin
            n_fail++;
            $display("FAIL mis_pulse: got %0d cycles expected 1", n_misal - m0);
        end
`else
        access(1'b0, 3'b010, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 32'hCAFE_F00D, "mis_force");
        n_checks++;
        if (n_misal != 0) begin
            n_fail++;
            $display("FAIL mis_tied: misalign seen high %0d cycles expected 0", n_misal);
        end
`endif
    endtask

    task automatic test_timeout();
        access(1'b0, 3'b010, 32'h2000_0000, 32'h0, 32'h1111_1111, -1, TO + 1, TO, 32'h0, "timeout");
        n_checks++;
        if (err_timeout !== 1'b1 || load_data_w !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_flag: got err=%b data=%h expected 1/00000000", err_timeout, load_data_w);
        end
        access(1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'h2222_2222, 0, 2, 1, 32'h2222_2222, "after_to");
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%b expected 1", err_timeout);
        end
    endtask

    task automatic test_reset_mid_wait();
        e_we = 1'b0; e_addr = 32'h3000_0000; e_be = 4'hF; e_wdata = 32'h0;
        resp_en = 1'b0; resp_cnt = 0;
        mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
        addr_m = 32'h3000_0000; wdata_m = 32'h0;
        repeat (3) tick();
        n_checks++;
        if (dbg_state !== 2'd1 || bus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_entry: got state=%0d req=%b expected 1/1", dbg_state, bus_req);
        end
        n_rst = 1'b0;
        mem_read_m = 1'b0;
        #1;
        check_reset_values("rst_async");
        #2;
        n_rst = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_values("rst_late_ack");
        end
        bus_ack = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_random();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_async.md
LSU_ASYNC -- requirements
Module: lsu_async

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before a bus access is abandoned.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports mem_read_m, mem_write_m  input  1 each  load/store request from the M stage.
REQ-006 SHALL have port funct3_m  input  3  size/sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
REQ-007 SHALL have ports addr_m, wdata_m  input  XLEN  byte address and store data.
REQ-008 SHALL have port stall_m  output  1  freezes the pipeline while an access is outstanding.
REQ-009 SHALL have ports load_data_w  output  XLEN  and load_valid_w  output  1  extended load result and its one-cycle strobe.
REQ-010 SHALL have ports bus_req, bus_we  output  1; bus_addr, bus_wdata  output  XLEN; bus_be  output  XLEN/8  memory request bundle.
REQ-011 SHALL have ports bus_rdata  input  XLEN  and bus_ack  input  1  memory response.
REQ-012 SHALL have ports err_timeout  output  1  (sticky) and misalign  output  1  (pulse).

Function
REQ-013 SHALL implement FSM IDLE, WAIT, DONE.
REQ-014 IDLE with mem_read_m or mem_write_m SHALL assert stall_m combinationally, register the bus bundle, and go to WAIT; mem_write_m wins if both asserted.
REQ-015 WAIT SHALL hold bus_req=1 and every bus output stable until bus_ack=1, then capture bus_rdata and go to DONE.
REQ-016 bus_ack SHALL be ignored outside WAIT.
REQ-017 DONE SHALL last exactly one cycle: stall_m=0, load_valid_w=1 for loads only, then IDLE without reissuing the request still presented in that cycle.
REQ-018 stall_m SHALL equal (IDLE and request) or WAIT; minimum latency request-to-DONE is 2 cycles with same-cycle ack.
REQ-019 bus_addr SHALL be addr_m with its low log2(XLEN/8) bits cleared; offset = those bits.
REQ-020 bus_be SHALL be size mask (B=1, H=3, W=0xF, D=0xFF) shifted left by offset; bus_wdata SHALL be wdata_m shifted left by 8*offset.
REQ-021 load_data_w SHALL be bus_rdata shifted right by 8*offset, then sign-extended (B,H,W) or zero-extended (BU,HU,WU) to XLEN; held until next DONE.
REQ-022 WAIT counter SHALL reach TIMEOUT_CYCLES without ack -> drop bus_req, set err_timeout, load_data_w=0, go to DONE.
REQ-023 Unsupported funct3 (111, or D/WU at XLEN=32) SHALL be treated as W.

Reset
REQ-024 n_rst low SHALL immediately force IDLE, counter 0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, load_data_w=0, load_valid_w=0, err_timeout=0, misalign=0; stall_m then follows REQ-018.
REQ-025 Reset during WAIT SHALL abandon the access; a later bus_ack SHALL have no effect.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined, an access whose offset is not a multiple of its size SHALL issue no bus_req, go IDLE->DONE (1 stall cycle), pulse misalign=1 in DONE, and return load_data_w=0.
REQ-027 Without LSU_MISALIGN_TRAP_EN, misalign SHALL be tied 0 and offset bits below the access size SHALL be forced to 0 before REQ-019..021.

Verification
REQ-028 LW addr 0x1000_0004, ack on first WAIT cycle, rdata 0xDEAD_BEEF -> bus_be=0xF, stall 2 cycles, load_data_w=0xDEAD_BEEF, load_valid_w one pulse.
REQ-029 LB addr 0x1000_0003, rdata 0x8000_0000 -> bus_be=0x8, load_data_w=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-030 SH addr 0x1000_0002, wdata 0x0000_1234, ack after 5 cycles -> bus_we=1, bus_be=0xC, bus_wdata=0x1234_0000 stable all WAIT cycles, load_valid_w stays 0.
REQ-031 LW with no ack, TIMEOUT_CYCLES=8 -> bus_req drops after 8 WAIT cycles, err_timeout=1 and stays 1 until n_rst.
REQ-032 n_rst pulsed mid-WAIT, then bus_ack -> all outputs at reset values, no load_valid_w.
REQ-033 LSU_MISALIGN_TRAP_EN defined, LW addr 0x1000_0002 -> no bus_req, misalign pulse, stall 1 cycle; undefined -> bus_be=0xF at 0x1000_0000.
